// File: rtl/imem_fetch_unit.sv
// Instruction fetch initiator: issues word-aligned reads, counts in-flight reads, and buffers {inst, pc} for decode.
// Optional IMEM_FETCH_MISALIGN_EN: a misaligned redirect halts fetch and queues a single misaligned-fetch marker.
module imem_fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0,
    parameter int          DEPTH      = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_imem_ready,
    output logic [31:0] o_imem_raddr,
    output logic        o_imem_ren,
    input  logic        i_imem_valid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_inst_misaligned,
    input  logic        i_inst_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
);

`ifdef IMEM_FETCH_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          halted;
    logic          mis_pending;
    logic [31:0]   mis_pc;

    logic [31:0] fifo_inst [DEPTH];
    logic [31:0] fifo_pc   [DEPTH];
    logic        fifo_mis  [DEPTH];

    logic        credit_ok;
    logic        issue;
    logic        resp;
    logic        resp_keep;
    logic        push;
    logic        pop;
    logic        redirect_mis;
    logic [31:0] redirect_aligned;
    logic [31:0] push_inst;
    logic [31:0] push_pc;

    // Handshakes: a memory request transfers on a cycle where o_imem_ren && i_imem_ready;
    // a response transfers on any cycle with i_imem_valid (no backpressure, in request order);
    // a decode transfer happens when o_inst_valid && i_inst_ready. A redirect suppresses
    // the request and the decode transfer of its own cycle.
    assign credit_ok = ((CW + 1)'(count) + (CW + 1)'(inflight)) < (CW + 1)'(DEPTH);
    assign o_imem_ren   = !i_rst && !i_redirect && credit_ok && !halted;
    assign o_imem_raddr = fetch_pc;

    assign issue     = o_imem_ren && i_imem_ready;
    assign resp      = i_imem_valid && (inflight != '0);
    assign resp_keep = resp && (drop == '0) && !i_redirect;
    assign push      = (resp_keep || mis_pending) && !i_redirect;
    assign pop       = o_inst_valid && i_inst_ready && !i_redirect;

    assign redirect_mis     = MIS_EN && (i_redirect_pc[1:0] != 2'b00);
    assign redirect_aligned = {i_redirect_pc[31:2], 2'b00};

    // The marker slot is only ever used right after a flush, so no response competes with it.
    assign push_inst = mis_pending ? 32'h0 : i_imem_rdata;
    assign push_pc   = mis_pending ? mis_pc : resp_pc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc <= RESET_ADDR;
            resp_pc  <= RESET_ADDR;
            inflight <= '0;
            drop     <= '0;
            count    <= '0;
            wptr     <= '0;
            rptr     <= '0;
        end else if (i_redirect) begin
            fetch_pc <= redirect_aligned;
            resp_pc  <= redirect_aligned;
            // Everything still outstanding after this cycle's response belongs to the old stream.
            inflight <= inflight - CW'(resp);
            drop     <= inflight - CW'(resp);
            count    <= '0;
            wptr     <= '0;
            rptr     <= '0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            inflight <= inflight + CW'(issue) - CW'(resp);
            if (resp && (drop != '0)) begin
                drop <= drop - CW'(1);
            end
            if (resp_keep) begin
                resp_pc <= resp_pc + 32'd4;
            end
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            halted      <= 1'b0;
            mis_pending <= 1'b0;
            mis_pc      <= RESET_ADDR;
        end else if (i_redirect) begin
            halted      <= redirect_mis;
            mis_pending <= redirect_mis;
            mis_pc      <= i_redirect_pc;
        end else begin
            mis_pending <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_inst[wptr] <= push_inst;
            fifo_pc[wptr]   <= push_pc;
            fifo_mis[wptr]  <= mis_pending;
        end
    end

    assign o_inst_valid      = (count != '0);
    assign o_inst            = o_inst_valid ? fifo_inst[rptr] : 32'h0;
    assign o_inst_pc         = o_inst_valid ? fifo_pc[rptr] : 32'h0;
    assign o_inst_misaligned = MIS_EN && o_inst_valid && fifo_mis[rptr];

endmodule

// File: doc/imem_fetch_unit.md
# imem_fetch_unit

Hart-side initiator for the instruction-memory request/response interface: issues word-aligned fetch requests to a `memory` instance, tracks in-flight reads, and buffers returned instructions with their PCs for the decode stage. It sits between the hart's PC/redirect logic and the `imem` port pins (`o_imem_raddr`, `o_imem_ren`, `i_imem_ready`, `i_imem_valid`, `i_imem_rdata`). It tolerates multi-cycle latency and issue interval, and discards stale responses after a redirect.

## Interface
- `RESET_ADDR`, 32'h0, fetch PC loaded on reset.
- `DEPTH`, 4, fetch buffer entries; power of two, ≥2. Also the cap on buffered plus in-flight words.
- `i_clk`  in  1  clock; all state updates on posedge.
- `i_rst`  in  1  one clock; reset is synchronous and active-high.
- `i_imem_ready`  in  1  memory can accept a request this cycle.
- `o_imem_raddr`  out  32  fetch address, always word-aligned (`[1:0]=0`).
- `o_imem_ren`  out  1  read request; accepted when `o_imem_ren && i_imem_ready`.
- `i_imem_valid`  in  1  read data returned; responses arrive in request order.
- `i_imem_rdata`  in  32  instruction word.
- `o_inst_valid`  out  1  buffer head holds an instruction.
- `o_inst`  out  32  head instruction.
- `o_inst_pc`  out  32  head PC.
- `o_inst_misaligned`  out  1  head is a misaligned-fetch marker (see Configuration).
- `i_inst_ready`  in  1  decode consumes the head when `o_inst_valid && i_inst_ready`.
- `i_redirect`  in  1  flush and restart fetch at `i_redirect_pc`.
- `i_redirect_pc`  in  32  new fetch PC.

## Operation
- State: `fetch_pc`, `inflight` (0..DEPTH), `drop` (0..DEPTH), and a DEPTH-entry FIFO of {inst, pc, misaligned} with read/write pointers plus count.
- A request issues when all hold: not in reset, `i_redirect` low, `count + inflight < DEPTH`, fetch not halted. The issued address is `fetch_pc`. An accepted request sets `fetch_pc += 4` and `inflight += 1`.
- `o_imem_ren` drops combinationally in any cycle with `i_redirect` high. `o_imem_raddr` is valid whenever `o_imem_ren` is high.
- Response handling with `drop == 0`: push {rdata, pc}. The pc comes from a parallel PC queue or from `resp_pc`, a counter that advances by 4 per accepted response. `inflight -= 1`.
- Response handling with `drop > 0`: discard the word. `drop -= 1`, `inflight -= 1`.
- Redirect in cycle N:
  - At edge N, clear the FIFO (count=0) and set `fetch_pc = {i_redirect_pc[31:2],2'b00}`.
  - Set `drop = inflight` (post-response value), so every response still outstanding is discarded.
  - A response arriving in cycle N is itself discarded.
  - Consume in cycle N is ignored.
- Simultaneous push and pop in the same cycle leaves count unchanged. Pop when empty is ignored. Push never overflows, because the credit rule prevents it.
- Pointers wrap modulo DEPTH. `inflight` and `drop` never exceed DEPTH.

## Timing
- Reset values: `o_imem_ren=0`, `o_imem_raddr=RESET_ADDR`, `o_inst_valid=0`, `o_inst=0`, `o_inst_pc=0`, `o_inst_misaligned=0`. Internally `inflight=drop=count=0` and `fetch_pc=RESET_ADDR`.
- `o_imem_ren` may assert in the first cycle after `i_rst` falls.
- The FIFO write happens at the edge where `i_imem_valid` is high. `o_inst_valid` rises the next cycle; there is no bypass. Request-to-`o_inst_valid` is LATENCY+1 cycles.
- Steady state with DEPTH≥LATENCY/INTERVAL and decode always ready: one request per memory INTERVAL, with no bubble from the credit cap.
- Reset mid-operation clears all counters and the FIFO. Responses arriving after reset are not dropped by the block; the memory is reset by the same `i_rst`.

## Configuration
- Macro `IMEM_FETCH_MISALIGN_EN`.
- Defined:
  - A redirect with `i_redirect_pc[1:0]!=0` halts fetch after the flush.
  - On the following cycle it pushes one entry {inst=0, pc=i_redirect_pc, misaligned=1}.
  - Fetch stays halted until the next redirect.
- Undefined:
  - `i_redirect_pc[1:0]` is ignored and fetch proceeds at the aligned address.
  - `o_inst_misaligned` is tied 0.

## Test plan
- Memory LATENCY=4, INTERVAL=2, words at 0x0/0x4/0x8 = 0x00500093/0x00A00113/0x002081B3, decode always ready:
  - First `o_inst_valid` at cycle 5 after reset release.
  - Heads in order: (pc 0x0, 0x00500093), (0x4, 0x00A00113), (0x8, 0x002081B3).
- Decode `i_inst_ready=0` for 20 cycles:
  - Exactly DEPTH=4 requests issue.
  - `o_imem_ren` stays low after that, and `count+inflight` never exceeds 4.
- Resume after stall:
  - FIFO drains 4 entries in order.
  - Fetch resumes at 0x10 with no lost or duplicated PC.
- Redirect to 0x40 with 2 requests in flight:
  - Next 2 `i_imem_valid` words are dropped.
  - The first head after the redirect has pc 0x40.
- Redirect in the same cycle as `i_imem_valid` and `i_inst_ready`:
  - The response is dropped and the pop is ignored.
  - The FIFO is empty the next cycle and `o_imem_raddr` equals the redirect target.
- Reset asserted with 3 in flight and 2 buffered, where the memory is reset by the same `i_rst`:
  - All outputs return to reset values.
  - After release, the first head is pc RESET_ADDR.
- With `IMEM_FETCH_MISALIGN_EN` defined:
  - Redirect to 0x42 yields one head {pc 0x42, misaligned=1} and no further requests.
  - A subsequent redirect to 0x80 restarts fetch.
